uart_fifo_bridge: RTL and testbench
===================================

// Module: uart_fifo_bridge
// PURPOSE
//  Parametrised UART transceiver with RX/TX FIFOs, valid/ready host streams and hardware echo mode.
//  Successor to the CSR-style UART plus external echo glue: adds buffering, framing/overflow status
//  and width/depth/baud generics. Sits between the board UART pins and any byte-stream consumer.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency, Hz
//  BAUD        115200    line rate; DIV = CLK_HZ/(16*BAUD), integer truncation, must be >= 1
//  DATA_BITS   8         data bits per frame, 5..9; 1 start, 1 stop, no parity
//  FIFO_AW     4         FIFO address width; each FIFO holds 2**FIFO_AW words
// PORTS
//  sys_clk      in   1            system clock, all logic on rising edge
//  sys_rst_n    in   1            asynchronous active-low reset
//  echo_en      in   1            1 = RX FIFO drains into TX FIFO internally
//  tx_data      in   DATA_BITS    host byte to transmit
//  tx_valid     in   1            host offers tx_data
//  tx_ready     out  1            TX FIFO accepts; push when tx_valid & tx_ready
//  rx_data      out  DATA_BITS    head of RX FIFO (valid only with rx_valid)
//  rx_valid     out  1            RX FIFO not empty and echo_en=0
//  rx_ready     in   1            host pops when rx_valid & rx_ready
//  rx_frame_err out  1            1-cycle pulse: stop bit sampled low, frame dropped
//  rx_overflow  out  1            1-cycle pulse: good frame dropped, RX FIFO full
//  rx_level     out  FIFO_AW+1    RX FIFO occupancy
//  tx_level     out  FIFO_AW+1    TX FIFO occupancy
//  uart_rx      in   1            serial input, asynchronous
//  uart_tx      out  1            serial output, idle high
// BEHAVIOUR
//  Reset: uart_tx=1, rx_valid=0, tx_ready=1, pulses=0, levels=0, both FSMs IDLE, FIFOs empty,
//   tick counter 0, uart_rx synchroniser flops =1. Reset mid-frame aborts it; uart_tx goes high at once.
//  Tick: free-running counter 0..DIV-1; tick=1 for one cycle at DIV-1. 16 ticks = one bit.
//  RX sync: 2-flop synchroniser; FSM sees delayed rxs. RX FSM IDLE->START->DATA->STOP->IDLE:
//   IDLE: rxs=0 -> START, oversample count os=0 (no tick alignment needed beyond count).
//   START: at os=7 re-sample; rxs=1 -> IDLE (glitch, no output); else os=0 -> DATA.
//   DATA: every 16 ticks sample mid-bit, shift in LSB first; after DATA_BITS samples -> STOP.
//   STOP: at mid-bit: rxs=0 -> rx_frame_err pulse, drop; rxs=1 & FIFO full -> rx_overflow, drop;
//    else push. Return to IDLE at that mid-bit (half-bit early, for resync).
//  TX FSM IDLE->START->DATA->STOP->IDLE: IDLE pops TX FIFO when non-empty (1 cycle, no tick wait);
//   each bit held 16 ticks; LSB first; STOP held 16 ticks then IDLE; back-to-back frames no gap.
//  Host: tx_ready = !tx_full & !echo_en. rx pop only when echo_en=0. FIFO read is first-word-fall-through.
//  Echo: when echo_en=1 and RX non-empty and TX not full: pop RX, push TX same cycle (1/cycle max).
//   echo_en change takes effect next cycle; words already in FIFOs are never lost or duplicated.
//  Simultaneous push+pop on a FIFO: allowed at any level incl. full (when popping) and empty
//   (push only lands; FWFT shows it next cycle). Level = wr_ptr - rd_ptr, FIFO_AW+1-bit pointers, wrap.
//  Latency: host push -> start bit on uart_tx <= 3 cycles + tick alignment 0 (TX starts on pop).
// STRUCTURE
//  Shared package/header uart_defs: FSM state encodings (IDLE,START,DATA,STOP), OS_MID=7, OS_LAST=15.
//  Sub-module uart_sync_fifo (WIDTH, AW; push/pop/full/empty/level, FWFT), instantiated twice.
//  RX FSM, TX FSM, tick gen and echo arbiter live in this module.
// TESTING  (sim params CLK_HZ=1600, BAUD=100 -> DIV=1, bit=16 cycles, DATA_BITS=8, FIFO_AW=2)
//  Drive frame 0xA5 on uart_rx -> rx_valid, rx_data=0xA5 within 10 cycles of stop mid-bit; rx_level=1.
//  Push 0x3C with tx_valid -> uart_tx low 16 cyc, bits 0,0,1,1,1,1,0,0 x16 cyc, high 16 cyc.
//  Frame 0x55 with stop bit low -> rx_frame_err 1 pulse, rx_level stays 0; 8-cycle low glitch -> nothing.
//  rx_ready=0, send 5 frames -> first 4 stored, 5th gives rx_overflow pulse; pops return 4 bytes in order.
//  echo_en=1, send 0x11,0x22,0x33 back-to-back -> same bytes on uart_tx in order, rx_valid stays 0.
//  Assert sys_rst_n low mid TX frame -> uart_tx=1 next edge, levels 0; new push transmits cleanly.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding and oversample checkpoints.
package uart_defs;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

  localparam logic [3:0] OS_MID  = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; one extra pointer bit separates full from empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  // A pop on a full FIFO frees the slot the same cycle, so push may land too.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// UART transceiver with RX/TX FIFOs, valid/ready host streams and internal echo path.
module uart_fifo_bridge
  import uart_defs::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 echo_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  output logic [FIFO_AW:0]     rx_level,
  output logic [FIFO_AW:0]     tx_level,
  input  logic                 uart_rx,
  output logic                 uart_tx
);

  localparam int         DIV       = CLK_HZ / (16 * BAUD);
  localparam int         TW        = cnt_w(DIV);
  localparam logic [3:0] BITS_LAST = 4'(DATA_BITS - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  tick_cnt <= '0;
    else if (tick)   tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  logic rx_s1, rx_s2, echo_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      echo_q <= 1'b0;
    end else begin
      rx_s1  <= uart_rx;
      rx_s2  <= rx_s1;
      echo_q <= echo_en;
    end
  end

  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] rx_sh, rx_head, tx_head, tx_wdata;
  logic                 echo_mv;

  // Echo moves at most one word per cycle and only while the host side is fenced off.
  assign echo_mv  = echo_q & ~rx_empty & ~tx_full;
  assign tx_ready = ~tx_full & ~echo_q;
  assign rx_valid = ~rx_empty & ~echo_q;
  assign rx_data  = rx_head;
  assign rx_pop   = echo_mv | (rx_valid & rx_ready);
  assign tx_push  = echo_mv | (tx_valid & tx_ready);
  assign tx_wdata = echo_mv ? rx_head : tx_data;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(sys_clk), .rst_n(sys_rst_n), .push(tx_push), .wdata(tx_wdata), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_st_e   rx_st;
  logic [3:0] rx_os, rx_bits;

  // rx_sh stays stable through the registered push: the next frame cannot shift for 8+ ticks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_st        <= ST_IDLE;
      rx_os        <= '0;
      rx_bits      <= '0;
      rx_sh        <= '0;
      rx_push      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      rx_push      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overflow  <= 1'b0;
      case (rx_st)
        ST_IDLE:
          if (!rx_s2) begin
            rx_st <= ST_START;
            rx_os <= '0;
          end
        ST_START:
          if (tick) begin
            if (rx_os == OS_MID) begin
              if (rx_s2) rx_st <= ST_IDLE;
              else begin
                rx_st   <= ST_DATA;
                rx_os   <= '0;
                rx_bits <= '0;
              end
            end else rx_os <= rx_os + 4'd1;
          end
        ST_DATA:
          if (tick) begin
            if (rx_os == OS_LAST) begin
              rx_os <= '0;
              rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
              if (rx_bits == BITS_LAST) rx_st <= ST_STOP;
              else                      rx_bits <= rx_bits + 4'd1;
            end else rx_os <= rx_os + 4'd1;
          end
        ST_STOP:
          if (tick) begin
            if (rx_os == OS_LAST) begin
              rx_st <= ST_IDLE;
              if (!rx_s2)       rx_frame_err <= 1'b1;
              else if (rx_full) rx_overflow  <= 1'b1;
              else              rx_push      <= 1'b1;
            end else rx_os <= rx_os + 4'd1;
          end
        default: rx_st <= ST_IDLE;
      endcase
    end
  end

  uart_st_e             tx_st;
  logic [3:0]           tx_os, tx_bits;
  logic [DATA_BITS-1:0] tx_sh;

  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop = ~tx_empty &
                  ((tx_st == ST_IDLE) | ((tx_st == ST_STOP) & tick & (tx_os == OS_LAST)));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_st   <= ST_IDLE;
      tx_os   <= '0;
      tx_bits <= '0;
      tx_sh   <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (tx_st)
        ST_IDLE:
          if (tx_pop) begin
            tx_st   <= ST_START;
            tx_sh   <= tx_head;
            tx_os   <= '0;
            uart_tx <= 1'b0;
          end
        ST_START:
          if (tick) begin
            if (tx_os == OS_LAST) begin
              tx_st   <= ST_DATA;
              tx_os   <= '0;
              tx_bits <= '0;
              uart_tx <= tx_sh[0];
            end else tx_os <= tx_os + 4'd1;
          end
        ST_DATA:
          if (tick) begin
            if (tx_os == OS_LAST) begin
              tx_os <= '0;
              if (tx_bits == BITS_LAST) begin
                tx_st   <= ST_STOP;
                uart_tx <= 1'b1;
              end else begin
                tx_bits <= tx_bits + 4'd1;
                tx_sh   <= tx_sh >> 1;
                uart_tx <= tx_sh[1];
              end
            end else tx_os <= tx_os + 4'd1;
          end
        ST_STOP:
          if (tick) begin
            if (tx_os == OS_LAST) begin
              tx_os <= '0;
              if (tx_pop) begin
                tx_st   <= ST_START;
                tx_sh   <= tx_head;
                uart_tx <= 1'b0;
              end else tx_st <= ST_IDLE;
            end else tx_os <= tx_os + 4'd1;
          end
        default: tx_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge at DIV=1 (16 cycles per bit), 8 data bits, 4-deep FIFOs.
module tb_uart_fifo_bridge;

  logic       sys_clk = 1'b0, sys_rst_n = 1'b0, echo_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, rx_ready = 1'b0, uart_rx = 1'b1;
  logic       tx_ready, rx_valid, rx_frame_err, rx_overflow, uart_tx;
  logic [7:0] rx_data;
  logic [2:0] rx_level, tx_level;

  int errors = 0, checks = 0;
  int fe_cnt = 0, ov_cnt = 0, rxv_echo = 0;

  uart_fifo_bridge #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .FIFO_AW(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .echo_en(echo_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overflow(rx_overflow),
    .rx_level(rx_level), .tx_level(tx_level),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (rx_frame_err)         fe_cnt   <= fe_cnt + 1;
    if (rx_overflow)          ov_cnt   <= ov_cnt + 1;
    if (echo_en && rx_valid)  rxv_echo <= rxv_echo + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0; step(16);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; step(16); end
    uart_rx = stop; step(16);
    uart_rx = 1'b1;
  endtask

  // Waits (bounded) for a start bit on uart_tx and samples each bit at mid-bit.
  task automatic capture_tx(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b1; b = 8'h00;
    while (uart_tx !== 1'b0 && n < 400) begin step(1); n++; end
    if (uart_tx !== 1'b0) begin ok = 1'b0; return; end
    step(8);
    if (uart_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin step(16); b[i] = uart_tx; end
    step(16);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; step(3);
    checks++; if (uart_tx !== 1'b1)     begin errors++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_level !== 3'd0)    begin errors++; $display("FAIL reset_rx_level got=%0d exp=0", rx_level); end
    checks++; if (tx_level !== 3'd0)    begin errors++; $display("FAIL reset_tx_level got=%0d exp=0", tx_level); end
    checks++; if ({rx_frame_err, rx_overflow} !== 2'b00)
      begin errors++; $display("FAIL reset_pulses got=%b exp=00", {rx_frame_err, rx_overflow}); end
    sys_rst_n = 1'b1; step(2);
  endtask

  task automatic test_rx_frame();
    int fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1); step(2);
    checks++; if (rx_valid !== 1'b1)  begin errors++; $display("FAIL rx_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'hA5)  begin errors++; $display("FAIL rx_data got=%h exp=a5", rx_data); end
    checks++; if (rx_level !== 3'd1)  begin errors++; $display("FAIL rx_level got=%0d exp=1", rx_level); end
    checks++; if (fe_cnt != fe0)      begin errors++; $display("FAIL rx_no_ferr got=%0d exp=%0d", fe_cnt, fe0); end
    rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    checks++; if (rx_level !== 3'd0)  begin errors++; $display("FAIL rx_pop_level got=%0d exp=0", rx_level); end
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL rx_pop_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] sym = {1'b1, 8'h3C, 1'b0};
    int n = 0;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready got=%b exp=1", tx_ready); end
    tx_data = 8'h3C; tx_valid = 1'b1; step(1); tx_valid = 1'b0;
    while (uart_tx !== 1'b0 && n < 5) begin step(1); n++; end
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL tx_start_latency got=%b exp=0 within 5", uart_tx); end
    for (int s = 0; s < 10; s++) begin
      int bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (uart_tx !== sym[s]) bad++;
        step(1);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL tx_sym%0d got %0d wrong cycles exp=%b", s, bad, sym[s]); end
    end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle got=%b exp=1", uart_tx); end
    checks++; if (tx_level !== 3'd0) begin errors++; $display("FAIL tx_level got=%0d exp=0", tx_level); end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt, ov0 = ov_cnt;
    send_frame(8'h55, 1'b0); step(20);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL ferr_level got=%0d exp=0", rx_level); end
    fe0 = fe_cnt;
    uart_rx = 1'b0; step(8); uart_rx = 1'b1; step(200);
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL glitch_level got=%0d exp=0", rx_level); end
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0)
      begin errors++; $display("FAIL glitch_pulses got fe=%0d ov=%0d exp fe=%0d ov=%0d", fe_cnt, ov_cnt, fe0, ov0); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h7E};
    int ov0 = ov_cnt;
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
    step(4);
    checks++; if (rx_level !== 3'd4)   begin errors++; $display("FAIL ovf_level got=%0d exp=4", rx_level); end
    checks++; if (ov_cnt - ov0 != 1)   begin errors++; $display("FAIL ovf_pulses got=%0d exp=1", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== bytes[i])
        begin errors++; $display("FAIL ovf_pop%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, bytes[i]); end
      rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    end
    checks++; if (rx_level !== 3'd0)   begin errors++; $display("FAIL ovf_drained got=%0d exp=0", rx_level); end
  endtask

  task automatic test_back_to_back_echo();
    logic [7:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] got [3];
    bit         ok [3];
    int rv0 = rxv_echo;
    echo_en = 1'b1; step(2);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL echo_tx_ready got=%b exp=0", tx_ready); end
    fork
      begin for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1); end
      begin for (int j = 0; j < 3; j++) capture_tx(got[j], ok[j]); end
    join
    for (int k = 0; k < 3; k++) begin
      checks++; if (!ok[k] || got[k] !== exp_b[k])
        begin errors++; $display("FAIL echo_byte%0d got=%h framed=%0d exp=%h", k, got[k], ok[k], exp_b[k]); end
    end
    step(16);
    checks++; if (rxv_echo != rv0)   begin errors++; $display("FAIL echo_rx_valid got %0d cycles exp 0", rxv_echo - rv0); end
    checks++; if (rx_level !== 3'd0 || tx_level !== 3'd0)
      begin errors++; $display("FAIL echo_levels got rx=%0d tx=%0d exp 0 0", rx_level, tx_level); end
    echo_en = 1'b0; step(2);
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] got;
    bit         ok;
    tx_data = 8'h96; tx_valid = 1'b1; step(1);
    tx_data = 8'hC3; step(1); tx_valid = 1'b0;
    step(20);
    checks++; if (uart_tx !== 1'b0)  begin errors++; $display("FAIL rst_pre_bit0 got=%b exp=0", uart_tx); end
    checks++; if (tx_level !== 3'd1) begin errors++; $display("FAIL rst_pre_level got=%0d exp=1", tx_level); end
    sys_rst_n = 1'b0; #1;
    checks++; if (uart_tx !== 1'b1)  begin errors++; $display("FAIL rst_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (tx_level !== 3'd0 || rx_level !== 3'd0)
      begin errors++; $display("FAIL rst_levels got tx=%0d rx=%0d exp 0 0", tx_level, rx_level); end
    step(2); sys_rst_n = 1'b1; step(2);
    tx_data = 8'h5A; tx_valid = 1'b1; step(1); tx_valid = 1'b0;
    capture_tx(got, ok);
    checks++; if (!ok || got !== 8'h5A) begin errors++; $display("FAIL rst_retx got=%h framed=%0d exp=5a", got, ok); end
    step(16);
    checks++; if (tx_level !== 3'd0 || uart_tx !== 1'b1)
      begin errors++; $display("FAIL rst_retx_idle got lvl=%0d tx=%b exp 0 1", tx_level, uart_tx); end
  endtask

  initial begin
    test_reset();
    test_rx_frame();
    test_tx_frame();
    test_frame_err();
    test_overflow();
    test_back_to_back_echo();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
